reg_bus_regfile: RTL

- Responder (slave) end of the team's single-phase register bus. Decodes master transactions into a bank of NumRegs DataWidth-bit registers.
- Features: byte-strobe writes, per-register read-only protection, programmable wait states, and a hardware update port.
- Sits behind a reg-bus demux or a bus-to-reg bridge. Exposes register contents to peripheral logic.

---
 rtl/reg_bus_regfile.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/reg_bus_regfile.sv
// -----------------------------------------------------------------------------
// reg_bus_regfile
//
// Responder end of the single-phase register bus. A bus request is decoded
// into a bank of NumRegs registers, each DataWidth bits wide. Supports
// byte-strobed writes, per-register read-only protection, a programmable
// number of wait states before the response, and a hardware update port that
// lets peripheral logic load registers directly.
//
// Ports:
//   clk_i        clock
//   rst_ni       asynchronous reset, active low
//   reg_addr_i   byte address of the access
//   reg_write_i  1 = write, 0 = read
//   reg_wdata_i  write data
//   reg_wstrb_i  byte strobes for writes
//   reg_valid_i  request valid
//   reg_rdata_o  read data, only non-zero during the response cycle
//   reg_error_o  error response, only valid during the response cycle
//   reg_ready_o  high for exactly one cycle when the transaction completes
//   hw_we_i      per-register hardware write enable
//   hw_wdata_i   hardware write data, register i in slice i
//   reg_q_o      current register contents, register i in slice i
// -----------------------------------------------------------------------------
module reg_bus_regfile #(
    parameter int unsigned                   AddrWidth    = 32,
    parameter int unsigned                   DataWidth    = 32,
    parameter int unsigned                   NumRegs      = 8,
    parameter int unsigned                   WaitCycles   = 0,
    parameter logic [NumRegs-1:0]            ReadOnlyMask = '0,
    parameter logic [NumRegs*DataWidth-1:0]  ResetValue   = '0
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [AddrWidth-1:0]           reg_addr_i,
    input  logic                           reg_write_i,
    input  logic [DataWidth-1:0]           reg_wdata_i,
    input  logic [DataWidth/8-1:0]         reg_wstrb_i,
    input  logic                           reg_valid_i,
    output logic [DataWidth-1:0]           reg_rdata_o,
    output logic                           reg_error_o,
    output logic                           reg_ready_o,
    input  logic [NumRegs-1:0]             hw_we_i,
    input  logic [NumRegs*DataWidth-1:0]   hw_wdata_i,
    output logic [NumRegs*DataWidth-1:0]   reg_q_o
);

    localparam int unsigned StrbWidth  = DataWidth / 8;
    localparam int unsigned OffsetBits = (StrbWidth > 1) ? $clog2(StrbWidth) : 0;
    localparam int unsigned IdxWidth   = (NumRegs > 1) ? $clog2(NumRegs) : 1;
    localparam logic [3:0]  WaitInit   = (WaitCycles > 0) ? 4'(WaitCycles - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    state_e                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;

    logic [AddrWidth-1:0]   req_addr_q;
    logic                   req_write_q;
    logic [DataWidth-1:0]   req_wdata_q;
    logic [StrbWidth-1:0]   req_wstrb_q;

    logic [DataWidth-1:0]   regs_q   [NumRegs];
    logic [DataWidth-1:0]   reg_next [NumRegs];

    logic [DataWidth-1:0]   rdata_q;
    logic                   error_q;
    logic                   commit_q;
    logic [IdxWidth-1:0]    resp_idx_q;

    logic [AddrWidth-1:0]   dec_addr;
    logic                   dec_write;
    logic [AddrWidth-1:0]   dec_word;
    logic [IdxWidth-1:0]    dec_idx;
    logic                   dec_misaligned;
    logic                   dec_in_range;
    logic                   dec_error;
    logic [DataWidth-1:0]   dec_rdata;
    logic                   commit_now;

    // Next-state logic for the handshake FSM. A request seen in IDLE either
    // goes straight to the response cycle or parks in WAIT while the counter
    // runs down from WaitCycles-1; the response cycle always returns to IDLE,
    // so a new request can only be taken in the cycle after ready.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (reg_valid_i) begin
                    if (WaitCycles == 0) begin
                        state_d = RESP;
                    end else begin
                        cnt_d   = WaitInit;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and wait counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The request is captured when it is accepted so that the transaction can
    // still finish cleanly if the master drops valid or changes the address
    // while we are waiting.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_addr_q  <= '0;
            req_write_q <= 1'b0;
            req_wdata_q <= '0;
            req_wstrb_q <= '0;
        end else if (state_q == IDLE && reg_valid_i) begin
            req_addr_q  <= reg_addr_i;
            req_write_q <= reg_write_i;
            req_wdata_q <= reg_wdata_i;
            req_wstrb_q <= reg_wstrb_i;
        end
    end

    // Address decode for the request that is about to be answered. With no
    // wait states the response is registered on the acceptance edge itself,
    // so the live bus inputs are decoded in IDLE; otherwise the captured copy
    // is used. Errors cover misaligned addresses, indices past the end of the
    // bank and writes to read-only registers. Only a good read returns data.
    always_comb begin
        dec_addr       = (state_q == IDLE) ? reg_addr_i  : req_addr_q;
        dec_write      = (state_q == IDLE) ? reg_write_i : req_write_q;
        dec_word       = dec_addr >> OffsetBits;
        dec_idx        = dec_word[IdxWidth-1:0];
        dec_misaligned = (dec_addr & AddrWidth'(StrbWidth - 1)) != '0;
        dec_in_range   = dec_word < AddrWidth'(NumRegs);
        dec_error      = dec_misaligned || !dec_in_range;
        dec_rdata      = '0;
        if (!dec_error && dec_write && ReadOnlyMask[dec_idx]) begin
            dec_error = 1'b1;
        end
        if (!dec_error && !dec_write) begin
            dec_rdata = regs_q[dec_idx];
        end
    end

    // Response registers. They are loaded on the edge into RESP, so the read
    // data reflects the register before any hardware update on that edge,
    // and they are cleared on every other edge, which keeps rdata and error
    // at zero whenever ready is low.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q    <= '0;
            error_q    <= 1'b0;
            commit_q   <= 1'b0;
            resp_idx_q <= '0;
        end else if (state_d == RESP) begin
            rdata_q    <= dec_rdata;
            error_q    <= dec_error;
            commit_q   <= dec_write && !dec_error;
            resp_idx_q <= dec_idx;
        end else begin
            rdata_q    <= '0;
            error_q    <= 1'b0;
            commit_q   <= 1'b0;
            resp_idx_q <= '0;
        end
    end

    assign commit_now = (state_q == RESP) && commit_q;

    // Next value of every register. A hardware update replaces the whole
    // word first; a bus write committing on the same edge then overrides just
    // its strobed bytes, so unstrobed bytes keep the hardware value.
    always_comb begin
        for (int i = 0; i < NumRegs; i++) begin
            reg_next[i] = regs_q[i];
            if (hw_we_i[i]) begin
                reg_next[i] = hw_wdata_i[i*DataWidth +: DataWidth];
            end
            if (commit_now && (resp_idx_q == IdxWidth'(i))) begin
                for (int b = 0; b < StrbWidth; b++) begin
                    if (req_wstrb_q[b]) begin
                        reg_next[i][b*8 +: 8] = req_wdata_q[b*8 +: 8];
                    end
                end
            end
        end
    end

    // Register bank storage, loaded from the per-register reset values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= ResetValue[i*DataWidth +: DataWidth];
            end
        end else begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= reg_next[i];
            end
        end
    end

    for (genvar g = 0; g < NumRegs; g++) begin : g_q
        assign reg_q_o[g*DataWidth +: DataWidth] = regs_q[g];
    end

    assign reg_ready_o = (state_q == RESP);
    assign reg_rdata_o = rdata_q;
    assign reg_error_o = error_q;

endmodule
